// File: rtl/stream_demux_pkg.sv
// Shared types and sizes for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {CH_EMPTY, CH_FULL} ch_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: single-entry buffer with valid/ready handshake and a
// wrapping count of words loaded into it.
//
// state    | meaning
// CH_EMPTY | no word buffered, valid low
// CH_FULL  | word buffered in data_q, valid high until the sink takes it
module demux_out_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data_q,
  output logic [CNT_W-1:0]  cnt
);

  ch_state_t state_q, state_d;
  logic      drain;

  assign valid = (state_q == CH_FULL);
  assign drain = valid & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CH_EMPTY;
    else     state_q <= state_d;
  end

  // A load while draining keeps the slot full; the new word overwrites in place.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_EMPTY: if (load)           state_d = CH_FULL;
      CH_FULL:  if (drain && !load) state_d = CH_EMPTY;
      default:                      state_d = CH_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt    <= '0;
    end else if (load) begin
      data_q <= data;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer: steers each accepted word to the
// one-entry buffer of the channel named by in_sel.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH*CNT_W-1:0]  cnt
);

  logic [N_CH-1:0] load;

  // Only the selected channel gates acceptance, so a stalled sink blocks nobody else.
  assign in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign load[i] = in_valid & in_ready & (in_sel == SEL_W'(i));

    demux_out_slot #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .data  (in_data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .data_q(out_data[i*DATA_W +: DATA_W]),
      .cnt   (cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed and random self-checking bench for stream_demux_1_4.
module tb_stream_demux_1_4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [31:0] cnt;

  int checks = 0;
  int failures = 0;

  stream_demux_1_4 #(.DATA_W(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = 2'd0;
    in_data = 4'h0;
    out_ready = 4'h0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h3;
    cyc();
    in_sel = 2'd3; in_data = 4'h7;
    cyc();
    #1;
    checks++;
    if (out_valid !== 4'b1010) begin
      failures++; $display("FAIL reset_prefill out_valid got %b want %b", out_valid, 4'b1010);
    end
    in_sel = 2'd1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_valid got %b want 0000", out_valid);
    end
    checks++;
    if (cnt !== 32'h0) begin
      failures++; $display("FAIL reset_cnt got %h want 0", cnt);
    end
    checks++;
    if (out_data !== 16'h0) begin
      failures++; $display("FAIL reset_data got %h want 0", out_data);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    cyc();
    cyc();
    rst = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 4'hA;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0010 || out_data[7:4] !== 4'hA) begin
      failures++; $display("FAIL post_reset_word valid %b data %h want 0010 a", out_valid, out_data[7:4]);
    end
    checks++;
    if (cnt[15:8] !== 8'd1) begin
      failures++; $display("FAIL post_reset_cnt1 got %0d want 1", cnt[15:8]);
    end
  endtask

  task automatic test_steering();
    do_reset();
    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = 4'(k + 1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL steer_in_ready ch%0d got %b want 1", k, in_ready);
      end
      cyc();
      checks++;
      if (out_valid !== (4'b0001 << k) || out_data[k*4 +: 4] !== 4'(k + 1)) begin
        failures++;
        $display("FAIL steer ch%0d valid %b data %h want %b %h", k, out_valid, out_data[k*4 +: 4],
                 4'b0001 << k, 4'(k + 1));
      end
    end
    in_valid = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL steer_drained got %b want 0000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 4'b1011;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 4'h5;
    cyc();
    in_data = 4'h6;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_blocked_in_ready got %b want 0", in_ready);
    end
    cyc();
    checks++;
    if (out_valid !== 4'b0100 || out_data[11:8] !== 4'h5) begin
      failures++; $display("FAIL bp_hold valid %b data %h want 0100 5", out_valid, out_data[11:8]);
    end
    in_sel = 2'd0; in_data = 4'h7;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_other_in_ready got %b want 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0101 || out_data[3:0] !== 4'h7 || out_data[11:8] !== 4'h5) begin
      failures++; $display("FAIL bp_isolation valid %b data %h want 0101 ch0=7 ch2=5", out_valid, out_data);
    end
    out_ready = 4'hF;
    cyc();
    checks++;
    if (out_valid !== 4'b0000 || out_data[11:8] !== 4'h5) begin
      failures++; $display("FAIL bp_drain valid %b ch2 %h want 0000 5", out_valid, out_data[11:8]);
    end
    in_valid = 1'b1; in_sel = 2'd2; in_data = 4'h6;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100 || out_data[11:8] !== 4'h6) begin
      failures++; $display("FAIL bp_follow valid %b ch2 %h want 0100 6", out_valid, out_data[11:8]);
    end
    checks++;
    if (cnt[23:16] !== 8'd2 || cnt[7:0] !== 8'd1) begin
      failures++; $display("FAIL bp_cnt cnt2 %0d cnt0 %0d want 2 1", cnt[23:16], cnt[7:0]);
    end
  endtask

  task automatic test_drain_load();
    do_reset();
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h8;
    cyc();
    out_ready = 4'b0010;
    in_data = 4'h9;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid[1] !== 1'b1 || out_data[7:4] !== 4'h8) begin
      failures++; $display("FAIL dl_pre rdy %b v %b d %h want 1 1 8", in_ready, out_valid[1], out_data[7:4]);
    end
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[7:4] !== 4'h9) begin
      failures++; $display("FAIL dl_replace v %b d %h want 1 9", out_valid[1], out_data[7:4]);
    end
    checks++;
    if (cnt[15:8] !== 8'd2) begin
      failures++; $display("FAIL dl_cnt got %0d want 2", cnt[15:8]);
    end
    cyc();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL dl_empty got %b want 0000", out_valid);
    end
  endtask

  // Continues from test_drain_load so channel 1 keeps a nonzero count.
  task automatic test_wrap();
    out_ready = 4'hF;
    in_valid = 1'b1; in_sel = 2'd3;
    for (int i = 0; i < 256; i++) begin
      in_data = 4'(i);
      cyc();
    end
    in_valid = 1'b0;
    checks++;
    if (cnt[31:24] !== 8'd0 || out_data[15:12] !== 4'hF) begin
      failures++; $display("FAIL wrap_256 cnt3 %0d d %h want 0 f", cnt[31:24], out_data[15:12]);
    end
    in_valid = 1'b1; in_data = 4'h2;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (cnt[31:24] !== 8'd1) begin
      failures++; $display("FAIL wrap_257 cnt3 %0d want 1", cnt[31:24]);
    end
    checks++;
    if (cnt[23:0] !== 24'h00_02_00) begin
      failures++; $display("FAIL wrap_others got %h want 000200", cnt[23:0]);
    end
  endtask

  task automatic test_random();
    logic [3:0] sbq [4][$];
    logic [7:0] mcnt [4];
    logic       exp_rdy;
    logic [3:0] w;
    do_reset();
    for (int c = 0; c < 4; c++) mcnt[c] = 8'd0;
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_sel    = 2'($urandom_range(3));
      in_data   = 4'($urandom_range(15));
      out_ready = 4'($urandom_range(15));
      #1;
      exp_rdy = (sbq[in_sel].size() == 0) || out_ready[in_sel];
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", n, in_ready, exp_rdy);
      end
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (out_valid[c] !== (sbq[c].size() != 0)) begin
          failures++; $display("FAIL rnd_valid cyc %0d ch%0d got %b want %b", n, c, out_valid[c], sbq[c].size() != 0);
        end else if (out_valid[c] && out_data[c*4 +: 4] !== sbq[c][0]) begin
          failures++; $display("FAIL rnd_data cyc %0d ch%0d got %h want %h", n, c, out_data[c*4 +: 4], sbq[c][0]);
        end
        if (sbq[c].size() != 0 && out_ready[c]) w = sbq[c].pop_front();
      end
      if (in_valid && exp_rdy) begin
        sbq[in_sel].push_back(in_data);
        mcnt[in_sel] = mcnt[in_sel] + 8'd1;
      end
      cyc();
    end
    in_valid = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (cnt[c*8 +: 8] !== mcnt[c]) begin
        failures++; $display("FAIL rnd_cnt ch%0d got %0d want %0d", c, cnt[c*8 +: 8], mcnt[c]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = 2'd0;
    in_data = 4'h0;
    out_ready = 4'h0;
    test_reset();
    test_steering();
    test_backpressure();
    test_drain_load();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
